// File: rtl/step_settle_monitor.sv
// Step-response settle monitor: tracks peak, overshoot and settling time of a
// sampled signed signal into a tolerance band, with a sample-count timeout.
module step_settle_monitor #(
  parameter int                      WIDTH         = 25,
  parameter logic signed [WIDTH-1:0] TARGET        = '0,
  parameter logic signed [WIDTH-1:0] TOL           = '0,
  parameter int                      SETTLE_CYCLES = 16,
  parameter int                      TIMEOUT       = 65535,
  parameter int                      CNT_WIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [WIDTH-1:0]     v_out,
  output logic                        busy,
  output logic                        done,
  output logic                        settled,
  output logic                        timeout,
  output logic        [CNT_WIDTH-1:0] settle_time,
  output logic signed [WIDTH-1:0]     peak,
  output logic signed [WIDTH-1:0]     overshoot
);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_DONE} state_t;

  localparam logic signed [WIDTH:0]   TGT_X    = {TARGET[WIDTH-1], TARGET};
  localparam logic signed [WIDTH:0]   TOL_X    = {TOL[WIDTH-1], TOL};
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  state_t                     state;
  logic       [CNT_WIDTH-1:0] index;
  logic       [CNT_WIDTH-1:0] run;
  logic       [CNT_WIDTH-1:0] candidate;

  logic signed [WIDTH:0]      diff;
  logic signed [WIDTH:0]      os_full;
  logic signed [WIDTH-1:0]    peak_next;
  logic signed [WIDTH-1:0]    os_sat;
  logic       [CNT_WIDTH-1:0] run_inc;
  logic                       in_band;
  logic                       hits_settle;
  logic                       last_idx;

  // One extra bit on the subtractions keeps extreme samples from wrapping into the band.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    diff        = $signed({v_out[WIDTH-1], v_out}) - TGT_X;
    in_band     = (diff <= TOL_X) && (diff >= -TOL_X);
    peak_next   = (v_out > peak) ? v_out : peak;
    run_inc     = run + CNT_WIDTH'(1);
    hits_settle = in_band && (run_inc == CNT_WIDTH'(SETTLE_CYCLES));
    last_idx    = (index == CNT_WIDTH'(TIMEOUT - 1));
    os_full     = $signed({peak_next[WIDTH-1], peak_next}) - TGT_X;
    os_sat      = os_full[WIDTH-1:0];
    if (os_full[WIDTH])        os_sat = '0;
    else if (os_full[WIDTH-1]) os_sat = MAX_POS;
  end

  assign busy = (state == S_TRACK);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      settled     <= 1'b0;
      timeout     <= 1'b0;
      settle_time <= '0;
      peak        <= '0;
      overshoot   <= '0;
      index       <= '0;
      run         <= '0;
      candidate   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_TRACK;
            settled     <= 1'b0;
            timeout     <= 1'b0;
            settle_time <= '0;
            overshoot   <= '0;
            peak        <= MOST_NEG;
            index       <= '0;
            run         <= '0;
          end
        end
        S_TRACK: begin
          peak  <= peak_next;
          index <= index + CNT_WIDTH'(1);
          run   <= in_band ? run_inc : '0;
          if (in_band && run == '0) candidate <= index;
          if (hits_settle) begin
            // With a single-sample requirement the run starts at this very index.
            state       <= S_DONE;
            settled     <= 1'b1;
            settle_time <= (run == '0) ? index : candidate;
            overshoot   <= os_sat;
            done        <= 1'b1;
          end else if (last_idx) begin
            state       <= S_DONE;
            timeout     <= 1'b1;
            settle_time <= CNT_WIDTH'(TIMEOUT);
            overshoot   <= os_sat;
            done        <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_settle_monitor.sv
// Bench for step_settle_monitor: directed step responses plus randomized traces,
// compared against a window-search reference model.
module tb_step_settle_monitor;

  localparam int W   = 16;
  localparam int TGT = 1000;
  localparam int TOL = 10;
  localparam int SC  = 4;
  localparam int TO  = 100;
  localparam int CW  = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic signed [W-1:0]  v_out = '0;
  logic                 busy, done, settled, timeout;
  logic        [CW-1:0] settle_time;
  logic signed [W-1:0]  peak, overshoot;

  int checks = 0;
  int failures = 0;

  logic signed [W-1:0] samp [0:TO+7];
  int seq_a [8]  = '{0, 500, 995, 1020, 1005, 1000, 1000, 1000};
  int seq_b [10] = '{990, 1010, 989, 1010, 990, 1011, 1000, 990, 1010, 1000};

  step_settle_monitor #(
    .WIDTH(W), .TARGET(W'(TGT)), .TOL(W'(TOL)),
    .SETTLE_CYCLES(SC), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .v_out(v_out),
    .busy(busy), .done(done), .settled(settled), .timeout(timeout),
    .settle_time(settle_time), .peak(peak), .overshoot(overshoot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_band(input int v);
    int d;
    d = v - TGT;
    return (d <= TOL) && (d >= -TOL);
  endfunction

  task automatic hold_from(input int n);
    for (int i = n; i <= TO + 7; i++) samp[i] = samp[n-1];
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".done"}, int'(done), 0);
    check({tag, ".settled"}, int'(settled), 0);
    check({tag, ".timeout"}, int'(timeout), 0);
    check({tag, ".settle_time"}, int'(settle_time), 0);
    check({tag, ".peak"}, int'(peak), 0);
    check({tag, ".overshoot"}, int'(overshoot), 0);
  endtask

  // Model: measurement ends at the first index closing a window of SC in-band samples,
  // otherwise at TIMEOUT-1; peak/overshoot cover samples up to and including that index.
  task automatic measure(input string tag, input int restart_at);
    int exp_end, exp_st, exp_pk, exp_os, got;
    bit exp_set, all_in;
    exp_end = TO - 1;
    exp_set = 1'b0;
    for (int i = SC - 1; i < TO; i++) begin
      all_in = 1'b1;
      for (int j = i - SC + 1; j <= i; j++) if (!in_band(int'(samp[j]))) all_in = 1'b0;
      if (all_in) begin
        exp_end = i;
        exp_set = 1'b1;
        break;
      end
    end
    exp_st = exp_set ? exp_end - SC + 1 : TO;
    exp_pk = -(1 << (W - 1));
    for (int i = 0; i <= exp_end; i++) if (int'(samp[i]) > exp_pk) exp_pk = int'(samp[i]);
    exp_os = exp_pk - TGT;
    if (exp_os < 0) exp_os = 0;
    if (exp_os > (1 << (W - 1)) - 1) exp_os = (1 << (W - 1)) - 1;

    @(negedge clk);
    start = 1'b1;
    v_out = W'($urandom);
    @(posedge clk); #1;
    check({tag, ".busy_on_start"}, int'(busy), 1);
    got = -1;
    for (int k = 0; k < TO + 4; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      v_out = samp[k];
      @(posedge clk); #1;
      if (done) begin
        got = k;
        break;
      end
    end
    check({tag, ".done_index"}, got, exp_end);
    check({tag, ".settled"}, int'(settled), int'(exp_set));
    check({tag, ".timeout"}, int'(timeout), int'(!exp_set));
    check({tag, ".settle_time"}, int'(settle_time), exp_st);
    check({tag, ".peak"}, int'(peak), exp_pk);
    check({tag, ".overshoot"}, int'(overshoot), exp_os);
    check({tag, ".busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, ".done_one_cycle"}, int'(done), 0);
    check({tag, ".settle_time_held"}, int'(settle_time), exp_st);
  endtask

  initial begin
    #1;
    check_zero("reset_init");
    #12;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i <= TO + 7; i++) samp[i] = W'(TGT);
    measure("hold_target", -1);

    // Async reset mid-cycle, while outputs are non-zero.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) samp[i] = W'(seq_a[i]);
    hold_from(8);
    measure("overshoot_step", -1);

    for (int i = 0; i <= TO + 7; i++) samp[i] = '0;
    measure("timeout_zero", -1);

    for (int i = 0; i < 10; i++) samp[i] = W'(seq_b[i]);
    hold_from(10);
    measure("band_edges", -1);

    for (int i = 0; i < 8; i++) samp[i] = W'(seq_a[i]);
    hold_from(8);
    measure("restart_ignored", 3);

    // Reset during tracking at sample 2.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    v_out = samp[0];
    @(negedge clk);
    v_out = samp[1];
    @(negedge clk);
    v_out = samp[2];
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_track_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_reset_idle", int'(done) + int'(busy), 0);
    end
    measure("fresh_after_reset", -1);

    for (int t = 0; t < 20; t++) begin
      int settle_at;
      settle_at = int'($urandom_range(110));
      for (int i = 0; i <= TO + 7; i++) begin
        if (i >= settle_at)          samp[i] = W'(TGT + int'($urandom_range(20)) - 10);
        else if ($urandom_range(3) == 0) samp[i] = W'($urandom);
        else                         samp[i] = W'(TGT + int'($urandom_range(40)) - 20);
      end
      measure($sformatf("rand%0d", t), int'($urandom_range(150)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
